fifo_multi_port: RTL

//  Multi-lane FIFO: accepts up to PUSH_N entries and delivers up to POP_N entries per cycle, in order.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mp_rotate.sv | 30 +++
 rtl/fifo_multi_port.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port FIFO.
//   min_u(a,b) : unsigned minimum, used to clip offered push/pop counts
//   cnt_w(n)   : bits needed to hold the values 0..n, used for CW/PW/QW
package fifo_pkg;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_mp_rotate.sv
// One pop lane of the multi-port FIFO.
// Picks mem[(rd_ptr + LANE) mod DEPTH] from the flattened storage. When
// fwd is high the lane shows the forwarded push lane instead. fwd is only
// driven high in the fall-through build.
// Ports:
//   mem_flat  in  DEPTH*DW  storage, entry k at [k*DW +: DW]
//   rd_ptr    in  AW        oldest entry index
//   fwd       in  1         select forwarded push data
//   fwd_data  in  DW        push lane with the same index as this pop lane
//   lane_data out DW        data presented on this pop lane
module fifo_mp_rotate import fifo_pkg::*; #(
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int LANE  = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [DEPTH*DW-1:0] mem_flat,
  input  logic [AW-1:0]       rd_ptr,
  input  logic                fwd,
  input  logic [DW-1:0]       fwd_data,
  output logic [DW-1:0]       lane_data
);

  logic [AW-1:0] idx;

  // DEPTH is a power of two, so the AW-bit add wraps modulo DEPTH.
  assign idx       = rd_ptr + AW'(LANE);
  assign lane_data = fwd ? fwd_data : mem_flat[idx*DW +: DW];

endmodule

// File: rtl/fifo_multi_port.sv
// Multi-lane in-order FIFO.
// Each cycle it accepts up to PUSH_N entries and delivers up to POP_N entries.
// Lanes are counted from lane 0. Push lanes that do not fit are dropped.
// Pop requests beyond valid_cnt are clipped.
//
// Handshake: push_cnt offers lanes 0..push_cnt-1. acc_push = min(push_cnt,
// free_slots) of them are taken on the rising edge. valid_cnt advertises pop
// lanes 0..valid_cnt-1. pop_cnt consumes acc_pop = min(pop_cnt, valid_cnt) of
// them on the same edge. A pop does not free space for a push in the same cycle.
//
// Optional macro FIFO_MP_FALLTHROUGH_EN: when the FIFO is empty and flush is
// low, push lanes are forwarded combinationally to the pop lanes. Forwarded
// lanes that are popped in the same cycle are never written to storage.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   flush       discard all entries, ignore same-cycle push/pop
//   push_data   PUSH_N lanes of DW bits; push_cnt lanes are offered
//   free_slots  DEPTH - count
//   push_ovf    pulse: the previous cycle offered more lanes than it accepted
//   pop_data    POP_N lanes of DW bits, oldest first
//   valid_cnt   number of valid pop lanes; pop_cnt lanes are consumed
module fifo_multi_port import fifo_pkg::*; #(
  parameter int DW     = 64,
  parameter int DEPTH  = 8,
  parameter int PUSH_N = 2,
  parameter int POP_N  = 2,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = cnt_w(PUSH_N),
  localparam int QW    = cnt_w(POP_N),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [PUSH_N*DW-1:0] push_data,
  input  logic [PW-1:0]        push_cnt,
  output logic [CW-1:0]        free_slots,
  output logic                 push_ovf,
  output logic [POP_N*DW-1:0]  pop_data,
  output logic [QW-1:0]        valid_cnt,
  input  logic [QW-1:0]        pop_cnt
);

  logic [DW-1:0]       mem [DEPTH];
  logic [DEPTH*DW-1:0] mem_flat;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                ovf_q;

  logic                fwd;
  logic [CW-1:0]       acc_push;
  logic [CW-1:0]       acc_pop;
  logic [CW-1:0]       skip;
  logic [QW-1:0]       valid_mem;

  assign free_slots = CW'(DEPTH) - count;
  assign push_ovf   = ovf_q;
  assign acc_push   = CW'(min_u(32'(push_cnt), 32'(free_slots)));
  assign valid_mem  = QW'(min_u(32'(count), POP_N));

`ifdef FIFO_MP_FALLTHROUGH_EN
  assign fwd       = (count == '0) && !flush;
  assign valid_cnt = fwd ? QW'(min_u(32'(acc_push), POP_N)) : valid_mem;
`else
  assign fwd       = 1'b0;
  assign valid_cnt = valid_mem;
`endif

  assign acc_pop = CW'(min_u(32'(pop_cnt), 32'(valid_cnt)));
  // Forwarded lanes that are popped at once bypass storage entirely.
  // Both pointers then skip them.
  assign skip    = fwd ? acc_pop : '0;

  always_comb begin
    mem_flat = '0;
    for (int k = 0; k < DEPTH; k++) mem_flat[k*DW +: DW] = mem[k];
  end

  for (genvar j = 0; j < POP_N; j++) begin : g_pop
    logic [DW-1:0] fwd_lane;
    if (j < PUSH_N) begin : g_fwd
      assign fwd_lane = push_data[j*DW +: DW];
    end else begin : g_nofwd
      assign fwd_lane = '0;
    end
    fifo_mp_rotate #(.DW(DW), .DEPTH(DEPTH), .LANE(j)) u_rot (
      .mem_flat  (mem_flat),
      .rd_ptr    (rd_ptr),
      .fwd       (fwd),
      .fwd_data  (fwd_lane),
      .lane_data (pop_data[j*DW +: DW])
    );
  end

  // Storage has no reset. Writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < PUSH_N; i++) begin
        if (i >= int'(skip) && i < int'(acc_push))
          mem[wr_ptr + AW'(i - int'(skip))] <= push_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(acc_push - skip);
      rd_ptr <= rd_ptr + AW'(acc_pop - skip);
      count  <= count + acc_push - acc_pop;
      ovf_q  <= 32'(push_cnt) > 32'(acc_push);
    end
  end

endmodule
